mix_add: RTL and testbench

MIX_ADD -- requirements
Module: mix_add

---
 rtl/mix_pkg.sv | 28 ++
 rtl/mix_char.sv | 89 ++++++++
 rtl/mix_add.sv | 85 ++++++++
 tb/tb_mix_add.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
// Shared MIX word geometry and CHAR encoding constants for the mix_add slice.
package mix_pkg;

   localparam int WORD_W      = 31;
   localparam int MAG_W       = 30;
   localparam int BYTE_W      = 6;
   localparam int SIGN_BIT    = 30;
   localparam int CHAR_OFFSET = 30;
   localparam int DIGIT_COUNT = 10;

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
   } mix_word_t;

   typedef enum logic {
      CHAR_IDLE,
      CHAR_BUSY
   } char_state_t;

   function automatic mix_word_t to_word(input logic [WORD_W-1:0] w);
      mix_word_t r;
      r.sign = w[SIGN_BIT];
      r.mag  = w[MAG_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/mix_char.sv
// CHAR converter: 30-bit binary magnitude to ten decimal character codes,
// one shift-and-add-3 step per clock.
module mix_char
   import mix_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          char_start,
   input  logic [MAG_W-1:0]              char_in,
   output logic                          char_stop,
   output logic [DIGIT_COUNT*BYTE_W-1:0] char_out
);

   localparam int BCD_W = DIGIT_COUNT * 4;

   char_state_t                   state_reg, state_next;
   logic [4:0]                    count_reg, count_next;
   logic [MAG_W-1:0]              bin_reg, bin_next;
   logic [BCD_W-1:0]              bcd_reg, bcd_next;
   logic [BCD_W-1:0]              bcd_adj;
   logic [BCD_W-1:0]              bcd_shift;
   logic                          stop_reg, stop_next;
   logic [DIGIT_COUNT*BYTE_W-1:0] out_reg, out_next;
   logic [DIGIT_COUNT*BYTE_W-1:0] out_enc;

   // Digit gi is counted from the least significant end, matching the byte order of char_out.
   genvar gi;
   generate
      for (gi = 0; gi < DIGIT_COUNT; gi++) begin : g_digit
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
         assign out_enc[gi*BYTE_W +: BYTE_W] = BYTE_W'(CHAR_OFFSET) + BYTE_W'(bcd_shift[gi*4 +: 4]);
      end
   endgenerate

   assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[MAG_W-1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= CHAR_IDLE;
         count_reg <= '0;
         bin_reg   <= '0;
         bcd_reg   <= '0;
         stop_reg  <= 1'b0;
         out_reg   <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         bin_reg   <= bin_next;
         bcd_reg   <= bcd_next;
         stop_reg  <= stop_next;
         out_reg   <= out_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      bin_next   = bin_reg;
      bcd_next   = bcd_reg;
      stop_next  = 1'b0;
      out_next   = out_reg;
      case (state_reg)
         CHAR_IDLE: begin
            if (char_start) begin
               bin_next   = char_in;
               bcd_next   = '0;
               count_next = '0;
               state_next = CHAR_BUSY;
            end
         end
         CHAR_BUSY: begin
            bin_next   = {bin_reg[MAG_W-2:0], 1'b0};
            bcd_next   = bcd_shift;
            count_next = count_reg + 5'd1;
            if (count_reg == 5'(MAG_W - 1)) begin
               state_next = CHAR_IDLE;
               stop_next  = 1'b1;
               out_next   = out_enc;
            end
         end
         default: state_next = CHAR_IDLE;
      endcase
   end

   assign char_stop = stop_reg;
   assign char_out  = out_reg;

endmodule

// File: rtl/mix_add.sv
// MIX ADD/SUB unit: single-cycle sign-magnitude add with registered result.
// Optional CHAR converter compiled in when MIX_ADD_CHAR_EN is defined.
module mix_add
   import mix_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          subtract,
   input  logic [WORD_W-1:0]             in1,
   input  logic [WORD_W-1:0]             in2,
   output logic                          stop,
   output logic [WORD_W-1:0]             out,
   output logic                          overflow
`ifdef MIX_ADD_CHAR_EN
   ,
   input  logic                          char_start,
   input  logic [MAG_W-1:0]              char_in,
   output logic                          char_stop,
   output logic [DIGIT_COUNT*BYTE_W-1:0] char_out
`endif
);

   mix_word_t         a_word, b_word;
   logic              b_sign;
   logic [MAG_W:0]    sum_ext;
   logic [MAG_W-1:0]  res_mag;
   logic              res_sign;
   logic              res_ovf;

   logic              stop_reg;
   logic [WORD_W-1:0] out_reg;
   logic              ovf_reg;

   assign a_word = to_word(in1);
   assign b_word = to_word(in2);
   assign b_sign = b_word.sign ^ subtract;
   assign sum_ext = {1'b0, a_word.mag} + {1'b0, b_word.mag};

   // A zero difference keeps the sign of in1, as does any same-sign sum.
   always_comb begin
      res_mag  = '0;
      res_sign = a_word.sign;
      res_ovf  = 1'b0;
      if (a_word.sign == b_sign) begin
         res_mag = sum_ext[MAG_W-1:0];
         res_ovf = sum_ext[MAG_W];
      end else if (a_word.mag > b_word.mag) begin
         res_mag = a_word.mag - b_word.mag;
      end else if (b_word.mag > a_word.mag) begin
         res_mag  = b_word.mag - a_word.mag;
         res_sign = b_sign;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stop_reg <= 1'b0;
         out_reg  <= '0;
         ovf_reg  <= 1'b0;
      end else begin
         stop_reg <= start;
         if (start) begin
            out_reg <= {res_sign, res_mag};
            ovf_reg <= res_ovf;
         end
      end
   end

   assign stop     = stop_reg;
   assign out      = out_reg;
   assign overflow = ovf_reg;

`ifdef MIX_ADD_CHAR_EN
   mix_char u_char (
      .clk        (clk),
      .reset      (reset),
      .char_start (char_start),
      .char_in    (char_in),
      .char_stop  (char_stop),
      .char_out   (char_out)
   );
`endif

endmodule

// File: tb/tb_mix_add.sv
// Self-checking bench for mix_add against an integer-arithmetic reference model.
// CHAR checks are included when MIX_ADD_CHAR_EN is defined.
module tb_mix_add;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        subtract;
   logic [30:0] in1;
   logic [30:0] in2;
   logic        stop;
   logic [30:0] out;
   logic        overflow;
`ifdef MIX_ADD_CHAR_EN
   logic        char_start;
   logic [29:0] char_in;
   logic        char_stop;
   logic [59:0] char_out;
`endif

   int n_vec = 0;
   int n_err = 0;

   localparam longint LIMIT = 64'd1073741824;

   always #5 clk = ~clk;

   mix_add dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .subtract   (subtract),
      .in1        (in1),
      .in2        (in2),
      .stop       (stop),
      .out        (out),
      .overflow   (overflow)
`ifdef MIX_ADD_CHAR_EN
      ,
      .char_start (char_start),
      .char_in    (char_in),
      .char_stop  (char_stop),
      .char_out   (char_out)
`endif
   );

   // Reference: treat words as signed integers, add, then re-encode as MIX sign-magnitude.
   function automatic void ref_add(input logic [30:0] a, input logic [30:0] b, input logic sub,
                                   output logic [30:0] r, output logic ov);
      longint va, vb, s, mag;
      va = longint'(a[29:0]);
      if (a[30]) va = -va;
      vb = longint'(b[29:0]);
      if (b[30] ^ sub) vb = -vb;
      s = va + vb;
      mag = (s < 0) ? -s : s;
      ov = (mag >= LIMIT);
      r[29:0] = 30'(mag % LIMIT);
      r[30] = (s == 0) ? a[30] : (s < 0);
   endfunction

   function automatic logic [30:0] mk(input logic sgn, input longint m);
      logic [30:0] w;
      w = {sgn, 30'(m)};
      return w;
   endfunction

   task automatic run_op(input string name, input logic [30:0] a, input logic [30:0] b, input logic sub);
      logic [30:0] er;
      logic        eo;
      ref_add(a, b, sub, er, eo);
      @(negedge clk);
      start = 1'b1; subtract = sub; in1 = a; in2 = b;
      @(posedge clk); #1;
      n_vec++;
      if (stop !== 1'b1 || out !== er || overflow !== eo) begin
         n_err++;
         $display("FAIL %s: in1=%h in2=%h sub=%0b got stop=%0b out=%h ovf=%0b want stop=1 out=%h ovf=%0b",
                  name, a, b, sub, stop, out, overflow, er, eo);
      end else
         $display("op %s: in1=%h in2=%h sub=%0b out=%h ovf=%0b", name, a, b, sub, out, overflow);
   endtask

   task automatic idle_start();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b1; subtract = 1'b0; in1 = mk(0, 5); in2 = mk(0, 7);
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (stop !== 1'b0 || out !== 31'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset: got stop=%0b out=%h ovf=%0b want 0/0/0", stop, out, overflow);
      end else
         $display("reset: stop=0 out=0 ovf=0");
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (stop !== 1'b0) begin
         n_err++;
         $display("FAIL reset_start_ignored: got stop=%0b want 0", stop);
      end
   endtask

   task automatic test_directed();
      run_op("add_5_7",   mk(0, 5), mk(0, 7), 1'b0);
      idle_start();
      run_op("sub_5_7",   mk(0, 5), mk(0, 7), 1'b1);
      idle_start();
      run_op("ovf_max_1", mk(0, LIMIT - 1), mk(0, 1), 1'b0);
      idle_start();
      run_op("neg3_pos3", mk(1, 3), mk(0, 3), 1'b0);
      idle_start();
      run_op("pos3_sub3", mk(0, 3), mk(0, 3), 1'b1);
      idle_start();
      run_op("neg_ovf",   mk(1, LIMIT - 2), mk(0, 5), 1'b1);
      idle_start();
      run_op("zero_zero", mk(1, 0), mk(0, 0), 1'b0);
      idle_start();
   endtask

   task automatic test_hold();
      logic [30:0] er;
      logic        eo;
      ref_add(mk(0, LIMIT - 1), mk(0, 10), 1'b0, er, eo);
      run_op("hold_src", mk(0, LIMIT - 1), mk(0, 10), 1'b0);
      @(negedge clk);
      start = 1'b0; in1 = mk(1, 77); in2 = mk(0, 1);
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (stop !== 1'b0 || out !== er || overflow !== eo) begin
         n_err++;
         $display("FAIL hold: got stop=%0b out=%h ovf=%0b want stop=0 out=%h ovf=%0b",
                  stop, out, overflow, er, eo);
      end else
         $display("hold: out=%h ovf=%0b", out, overflow);
   endtask

   task automatic test_random(input int count);
      logic [30:0] a, b;
      logic        sub;
      longint      ma, mb;
      for (int i = 0; i < count; i++) begin
         case ($urandom_range(0, 3))
            0: begin ma = $urandom_range(0, 1000);       mb = $urandom_range(0, 1000); end
            1: begin ma = $urandom_range(0, 32'h3FFFFFFF); mb = ma; end
            2: begin ma = LIMIT - 1 - $urandom_range(0, 50); mb = $urandom_range(0, 100); end
            default: begin ma = $urandom_range(0, 32'h3FFFFFFF); mb = $urandom_range(0, 32'h3FFFFFFF); end
         endcase
         a = mk(1'($urandom_range(0, 1)), ma);
         b = mk(1'($urandom_range(0, 1)), mb);
         sub = 1'($urandom_range(0, 1));
         run_op($sformatf("rand%0d", i), a, b, sub);
         if ($urandom_range(0, 1) == 1) idle_start();
      end
      idle_start();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         run_op($sformatf("b2b%0d", i), mk(1'(i % 2), 100 * i + 3), mk(1'(i / 4), 50 * i), 1'(i % 3 == 0));
      idle_start();
      @(posedge clk); #1;
      n_vec++;
      if (stop !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_tail: got stop=%0b want 0", stop);
      end
   endtask

   task automatic test_reset_abort();
      run_op("pre_abort", mk(0, 1234), mk(0, 1), 1'b0);
      @(negedge clk);
      start = 1'b1; in1 = mk(1, 9); in2 = mk(0, 2); subtract = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (stop !== 1'b0 || out !== 31'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL abort_same: got stop=%0b out=%h ovf=%0b want 0/0/0", stop, out, overflow);
      end
      @(negedge clk);
      reset = 1'b0; start = 1'b1; in1 = mk(0, LIMIT - 1); in2 = mk(0, 3);
      @(negedge clk);
      start = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (stop !== 1'b0 || out !== 31'd0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL abort_next: got stop=%0b out=%h ovf=%0b want 0/0/0", stop, out, overflow);
      end else
         $display("abort: stop=0 out=0 ovf=0");
      @(negedge clk);
      reset = 1'b0;
   endtask

`ifdef MIX_ADD_CHAR_EN
   function automatic logic [59:0] ref_char(input longint v);
      logic [59:0] r;
      longint      x;
      x = v;
      for (int i = 0; i < 10; i++) begin
         r[i*6 +: 6] = 6'(30 + (x % 10));
         x = x / 10;
      end
      return r;
   endfunction

   task automatic run_char(input string name, input logic [29:0] v, input bit poke_busy);
      logic [59:0] exp_out;
      int          seen;
      exp_out = ref_char(longint'(v));
      @(negedge clk);
      char_start = 1'b1; char_in = v;
      @(negedge clk);
      char_start = 1'b0;
      seen = -1;
      for (int k = 1; k <= 40 && seen < 0; k++) begin
         if (poke_busy && k == 5) begin
            char_start = 1'b1; char_in = ~v;
         end else
            char_start = 1'b0;
         if (k == 1) begin
            #1;
            if (char_stop === 1'b1) seen = 0;
         end
         if (seen < 0) begin
            @(posedge clk); #1;
            if (char_stop === 1'b1) seen = k;
            @(negedge clk);
         end
      end
      char_start = 1'b0;
      n_vec++;
      if (seen != 30) begin
         n_err++;
         $display("FAIL %s_latency: char_stop after %0d edges want 30", name, seen);
      end
      n_vec++;
      if (char_out !== exp_out) begin
         n_err++;
         $display("FAIL %s_value: char_out=%h want %h", name, char_out, exp_out);
      end else
         $display("char %s: in=%0d out=%h", name, v, char_out);
   endtask

   task automatic test_char();
      run_char("char_ref", 30'd12977699, 1'b0);
      run_char("char_max", 30'h3FFFFFFF, 1'b0);
      run_char("char_busy", 30'($urandom_range(0, 32'h3FFFFFFF)), 1'b1);
      for (int i = 0; i < 3; i++)
         run_char($sformatf("char_rand%0d", i), 30'($urandom_range(0, 32'h3FFFFFFF)), 1'b0);
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; subtract = 1'b0; in1 = '0; in2 = '0;
`ifdef MIX_ADD_CHAR_EN
      char_start = 1'b0; char_in = '0;
`endif
      test_reset();
      test_directed();
      test_hold();
      test_random(150);
      test_back_to_back();
      test_reset_abort();
`ifdef MIX_ADD_CHAR_EN
      test_char();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
